// File: rtl/fp_addsub_seq_if.sv
`default_nettype none
// ============================================================================
// Module : fp_addsub_seq_if
// Brief  : Operand/result valid-ready bundle for the sequential FP add/sub unit
// Rev    : 1.0
// ============================================================================
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module : fp_addsub_seq
// Brief  : Multi-cycle IEEE-754 add/subtract, RNE rounding, subnormals, flags
// Rev    : 1.0
// ============================================================================
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic           clk,
  input  logic           rst,
  fp_addsub_seq_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + 1;

  localparam logic [EXP_W-1:0] C_EXP_ONES = '1;
  localparam logic [XW-1:0]    C_SAT      = XW'(MAN_W + 3);
  localparam logic [W-1:0]     C_QNAN     = {1'b0, C_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_ALIGN = 3'd1;
  localparam logic [2:0] C_ADD   = 3'd2;
  localparam logic [2:0] C_NORM  = 3'd3;
  localparam logic [2:0] C_ROUND = 3'd4;
  localparam logic [2:0] C_DONE  = 3'd5;

  logic [2:0]    r_state;
  logic [W-1:0]  r_a, r_b;
  logic          r_sub;
  logic [SW-1:0] r_sig_l, r_sig_s;
  logic          r_sign_l, r_sign_s;
  logic [XW-1:0] r_exp;
  logic [SW:0]   r_sum;
  logic [W-1:0]  r_result;
  logic [3:0]    r_flags;

  // Operand decode and alignment
  logic             w_sa, w_sb, w_a_big;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_snan;
  logic [SW-1:0]    w_sig_a, w_sig_b, w_sig_small, w_sig_sh, w_mask, w_sig_al;
  logic [XW-1:0]    w_xa, w_xb, w_xl, w_diff, w_shamt;

  assign w_sa    = r_a[W-1];
  assign w_sb    = r_b[W-1] ^ r_sub;
  assign w_ea    = r_a[W-2:MAN_W];
  assign w_eb    = r_b[W-2:MAN_W];
  assign w_ma    = r_a[MAN_W-1:0];
  assign w_mb    = r_b[MAN_W-1:0];
  assign w_nan_a = (&w_ea) & (|w_ma);
  assign w_nan_b = (&w_eb) & (|w_mb);
  assign w_inf_a = (&w_ea) & ~(|w_ma);
  assign w_inf_b = (&w_eb) & ~(|w_mb);
  assign w_snan  = (w_nan_a & ~w_ma[MAN_W-1]) | (w_nan_b & ~w_mb[MAN_W-1]);

  // Raw field compare orders magnitudes correctly, subnormals included
  assign w_a_big     = r_a[W-2:0] >= r_b[W-2:0];
  assign w_sig_a     = {|w_ea, w_ma, 3'b000};
  assign w_sig_b     = {|w_eb, w_mb, 3'b000};
  assign w_xa        = (|w_ea) ? {1'b0, w_ea} : XW'(1);
  assign w_xb        = (|w_eb) ? {1'b0, w_eb} : XW'(1);
  assign w_xl        = w_a_big ? w_xa : w_xb;
  assign w_diff      = w_a_big ? (w_xa - w_xb) : (w_xb - w_xa);
  assign w_shamt     = (w_diff > C_SAT) ? C_SAT : w_diff;
  assign w_sig_small = w_a_big ? w_sig_b : w_sig_a;
  assign w_sig_sh    = w_sig_small >> w_shamt;
  assign w_mask      = (SW'(1) << w_shamt) - SW'(1);
  assign w_sig_al    = {w_sig_sh[SW-1:1], w_sig_sh[0] | (|(w_sig_small & w_mask))};

  logic [SW:0] w_sum;
  assign w_sum = (r_sign_l == r_sign_s) ? ({1'b0, r_sig_l} + {1'b0, r_sig_s})
                                        : ({1'b0, r_sig_l} - {1'b0, r_sig_s});

  // Round to nearest even; a subnormal that rounds up into the hidden bit keeps exponent 1
  logic [MAN_W:0]   w_mant;
  logic             w_inexact, w_rup, w_ovf;
  logic [MAN_W+1:0] w_rnd;
  logic [XW-1:0]    w_exp_f;
  logic [MAN_W-1:0] w_man_f;

  assign w_mant    = r_sum[MAN_W+3:3];
  assign w_inexact = |r_sum[2:0];
  assign w_rup     = r_sum[2] & (r_sum[1] | r_sum[0] | w_mant[0]);
  assign w_rnd     = {1'b0, w_mant} + (MAN_W+2)'(w_rup);
  assign w_exp_f   = w_rnd[MAN_W+1] ? (r_exp + XW'(1)) : (w_rnd[MAN_W] ? r_exp : '0);
  assign w_man_f   = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_ovf     = w_exp_f >= {1'b0, C_EXP_ONES};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= C_IDLE;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sub   <= bus.op_sub;
            r_state <= C_ALIGN;
          end
        end
        C_ALIGN: begin
          r_state <= C_DONE;
          r_flags <= '0;
          if (w_nan_a | w_nan_b) begin
            r_result <= C_QNAN;
            r_flags  <= {w_snan, 3'b000};
          end else if (w_inf_a & w_inf_b & (w_sa ^ w_sb)) begin
            r_result <= C_QNAN;
            r_flags  <= 4'b1000;
          end else if (w_inf_a) begin
            r_result <= {w_sa, C_EXP_ONES, {MAN_W{1'b0}}};
          end else if (w_inf_b) begin
            r_result <= {w_sb, C_EXP_ONES, {MAN_W{1'b0}}};
          end else begin
            r_state  <= C_ADD;
            r_sig_l  <= w_a_big ? w_sig_a : w_sig_b;
            r_sig_s  <= w_sig_al;
            r_sign_l <= w_a_big ? w_sa : w_sb;
            r_sign_s <= w_a_big ? w_sb : w_sa;
            r_exp    <= w_xl;
          end
        end
        C_ADD: begin
          if (w_sum == '0) begin
            r_result <= {r_sign_l & r_sign_s, {(W-1){1'b0}}};
            r_flags  <= '0;
            r_state  <= C_DONE;
          end else begin
            r_sum   <= w_sum;
            r_state <= C_NORM;
          end
        end
        C_NORM: begin
          if (r_sum[MAN_W+4]) begin
            r_sum   <= {1'b0, r_sum[MAN_W+4:2], r_sum[1] | r_sum[0]};
            r_exp   <= r_exp + XW'(1);
            r_state <= C_ROUND;
          end else if (!r_sum[MAN_W+3] && (r_exp > XW'(1))) begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - XW'(1);
          end else begin
            r_state <= C_ROUND;
          end
        end
        C_ROUND: begin
          r_state <= C_DONE;
          if (w_ovf) begin
            r_result <= {r_sign_l, C_EXP_ONES, {MAN_W{1'b0}}};
            r_flags  <= 4'b0101;
          end else begin
            r_result <= {r_sign_l, w_exp_f[EXP_W-1:0], w_man_f};
            r_flags  <= {2'b00, w_inexact & ~(|w_exp_f), w_inexact};
          end
        end
        C_DONE: begin
          if (bus.out_ready) r_state <= C_IDLE;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == C_IDLE);
  assign bus.out_valid = (r_state == C_DONE);
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule
`default_nettype wire
